// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for mem_port_arbiter: FSM states, access-size
// encodings, requester ids and the beat-count helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam logic [2:0] FETCH_BEATS = 3'd4;

    // Encoding 3 is not a legal size and is served as a full word.
    function automatic logic [2:0] beats_from_size(input logic [1:0] size);
        logic [2:0] beats;
        case (size)
            SIZE_B:  beats = 3'd1;
            SIZE_H:  beats = 3'd2;
            SIZE_W:  beats = 3'd4;
            default: beats = 3'd4;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and byte-memory port of mem_port_arbiter.
// The arbiter takes the slave modport; requesters and memory sit on master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 6
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_ack, d_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant selection between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin; otherwise data has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req_i,
    input  logic d_req_i,
`ifdef MEM_ARB_RR_EN
    input  logic last_gnt_i,
`endif
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    // Pick a winner; on contention the policy depends on the build option.
    always_comb begin
        gnt_valid_o = if_req_i | d_req_i;
        gnt_id_o    = REQ_IF;
        if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
            if (last_gnt_i == REQ_D) begin
                gnt_id_o = REQ_IF;
            end else begin
                gnt_id_o = REQ_D;
            end
`else
            gnt_id_o = REQ_D;
`endif
        end else if (d_req_i) begin
            gnt_id_o = REQ_D;
        end else begin
            gnt_id_o = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store requests into little-endian byte beats on a
// single-port byte memory. Build option MEM_ARB_RR_EN enables round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic               clock,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        beats_q, beats_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    logic              gnt_valid_s;
    logic              gnt_id_s;
    logic [ADDR_W-1:0] beat_addr_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_we_s;
    logic [7:0]        mem_wdata_s;

`ifdef MEM_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;

    // Remember who won the most recent grant for round-robin fairness.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_q <= REQ_IF;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    // Update the last-grant record on every grant issued from IDLE.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if ((state_q == IDLE) && gnt_valid_s) begin
            last_gnt_d = gnt_id_s;
        end else begin
            last_gnt_d = last_gnt_q;
        end
    end
`endif

    mem_arb_pick u_pick (
        .if_req_i    (bus.if_req),
        .d_req_i     (bus.d_req),
`ifdef MEM_ARB_RR_EN
        .last_gnt_i  (last_gnt_q),
`endif
        .gnt_valid_o (gnt_valid_s),
        .gnt_id_o    (gnt_id_s)
    );

    // Sequencer state and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gnt_q      <= REQ_IF;
            base_q     <= {ADDR_W{1'b0}};
            beats_q    <= 3'd0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            cnt_q      <= 2'd0;
            result_q   <= 32'd0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            base_q     <= base_d;
            beats_q    <= beats_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state logic: latch a grant, step through beats, then acknowledge.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        base_d     = base_q;
        beats_d    = beats_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid_s) begin
                    state_d  = BEAT;
                    gnt_d    = gnt_id_s;
                    cnt_d    = 2'd0;
                    result_d = 32'd0;
                    if (gnt_id_s == REQ_D) begin
                        base_d  = bus.d_addr[ADDR_W-1:0];
                        beats_d = beats_from_size(bus.d_size);
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                    end else begin
                        base_d  = bus.if_addr[ADDR_W-1:0];
                        beats_d = FETCH_BEATS;
                        we_d    = 1'b0;
                        wdata_d = 32'd0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            BEAT: begin
                if (!we_q) begin
                    result_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
                end else begin
                    result_d = result_q;
                end
                cnt_d = cnt_q + 2'd1;
                // The final beat's byte is folded in here so the ack cycle
                // already presents the complete word.
                if ({1'b0, cnt_q} == (beats_q - 3'd1)) begin
                    state_d = ACK;
                    cnt_d   = 2'd0;
                    if (gnt_q == REQ_D) begin
                        d_ack_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = result_d;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = result_d;
                    end
                end else begin
                    state_d = BEAT;
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign beat_addr_s = base_q + {{(ADDR_W-2){1'b0}}, cnt_q};

    // Memory port decode, driven only from registered state.
    always_comb begin
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_we_s    = 1'b0;
        mem_wdata_s = 8'd0;
        if (state_q == BEAT) begin
            mem_addr_s = beat_addr_s;
            mem_we_s   = we_q;
            if (we_q) begin
                mem_wdata_s = wdata_q[{cnt_q, 3'b000} +: 8];
            end else begin
                mem_wdata_s = 8'd0;
            end
        end else begin
            mem_addr_s  = {ADDR_W{1'b0}};
            mem_we_s    = 1'b0;
            mem_wdata_s = 8'd0;
        end
    end

    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 64-byte memory model.
// Expectations follow the round-robin policy when MEM_ARB_RR_EN is defined.
module tb_mem_port_arbiter;

    logic clock;
    logic reset_n;
    int   tests;
    int   fails;

    mem_port_arbiter_if #(.ADDR_W(6)) bus ();

    mem_port_arbiter #(.ADDR_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    logic [7:0] mem [0:63];
    logic       poke_en;
    logic [5:0] poke_addr;
    logic [7:0] poke_data;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte memory: bench preload has priority over the DUT write strobe.
    always @(posedge clock) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic poke(input logic [5:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(negedge clock);
        poke_en   = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (bus.if_ack !== 1'b0) begin fails++; $display("FAIL rst_if_ack: got %b expected 0", bus.if_ack); end
        tests++; if (bus.d_ack !== 1'b0) begin fails++; $display("FAIL rst_d_ack: got %b expected 0", bus.d_ack); end
        tests++; if (bus.if_rdata !== 32'd0) begin fails++; $display("FAIL rst_if_rdata: got %h expected 0", bus.if_rdata); end
        tests++; if (bus.d_rdata !== 32'd0) begin fails++; $display("FAIL rst_d_rdata: got %h expected 0", bus.d_rdata); end
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
        tests++; if (bus.mem_addr !== 6'd0) begin fails++; $display("FAIL rst_mem_addr: got %0d expected 0", bus.mem_addr); end
        tests++; if (bus.mem_wdata !== 8'd0) begin fails++; $display("FAIL rst_mem_wdata: got %h expected 0", bus.mem_wdata); end
    endtask

    task automatic test_fetch_word();
        int   ack_cyc;
        logic saw_we;
        poke(6'd0, 8'h23);
        poke(6'd1, 8'hA2);
        poke(6'd2, 8'h20);
        poke(6'd3, 8'h00);
        ack_cyc = 0;
        saw_we  = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (bus.mem_we) saw_we = 1'b1;
            if (bus.if_ack) begin ack_cyc = k; break; end
        end
        bus.if_req = 1'b0;
        tests++; if (ack_cyc !== 5) begin fails++; $display("FAIL fetch_ack_cycle: got %0d expected 5", ack_cyc); end
        tests++; if (bus.if_rdata !== 32'h0020A223) begin fails++; $display("FAIL fetch_rdata: got %h expected 0020a223", bus.if_rdata); end
        tests++; if (saw_we !== 1'b0) begin fails++; $display("FAIL fetch_no_we: got %b expected 0", saw_we); end
        @(negedge clock);
        tests++; if (bus.if_ack !== 1'b0) begin fails++; $display("FAIL fetch_ack_pulse: got %b expected 0", bus.if_ack); end
        tests++; if (bus.if_rdata !== 32'h0020A223) begin fails++; $display("FAIL fetch_rdata_hold: got %h expected 0020a223", bus.if_rdata); end
    endtask

    task automatic test_store_load();
        int          ack_cyc;
        int          nwe;
        logic [31:0] wa;
        logic [31:0] wd;
        ack_cyc = 0; nwe = 0; wa = 32'd0; wd = 32'd0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'd2;
        bus.d_addr = 32'd8; bus.d_wdata = 32'hDEADBEEF;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (bus.mem_we) begin
                nwe++;
                wa = {wa[23:0], 2'b00, bus.mem_addr};
                wd = {wd[23:0], bus.mem_wdata};
            end
            if (bus.d_ack) begin ack_cyc = k; break; end
        end
        bus.d_req = 1'b0;
        tests++; if (ack_cyc !== 5) begin fails++; $display("FAIL store_ack_cycle: got %0d expected 5", ack_cyc); end
        tests++; if (nwe !== 4) begin fails++; $display("FAIL store_we_count: got %0d expected 4", nwe); end
        tests++; if (wa !== 32'h08090A0B) begin fails++; $display("FAIL store_addr_seq: got %h expected 08090a0b", wa); end
        tests++; if (wd !== 32'hEFBEADDE) begin fails++; $display("FAIL store_data_seq: got %h expected efbeadde", wd); end
        tests++; if (bus.d_rdata !== 32'd0) begin fails++; $display("FAIL store_rdata_kept: got %h expected 0", bus.d_rdata); end
        @(negedge clock);
        tests++; if ({mem[11], mem[10], mem[9], mem[8]} !== 32'hDEADBEEF) begin
            fails++; $display("FAIL store_mem: got %h expected deadbeef", {mem[11], mem[10], mem[9], mem[8]}); end

        ack_cyc = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_addr = 32'd10;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (bus.d_ack) begin ack_cyc = k; break; end
        end
        bus.d_req = 1'b0;
        tests++; if (ack_cyc !== 2) begin fails++; $display("FAIL ldb_ack_cycle: got %0d expected 2", ack_cyc); end
        tests++; if (bus.d_rdata !== 32'h000000AD) begin fails++; $display("FAIL ldb_rdata: got %h expected 000000ad", bus.d_rdata); end
        @(negedge clock);

        ack_cyc = 0;
        bus.d_req = 1'b1; bus.d_size = 2'd1; bus.d_addr = 32'd8;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (bus.d_ack) begin ack_cyc = k; break; end
        end
        bus.d_req = 1'b0;
        tests++; if (ack_cyc !== 3) begin fails++; $display("FAIL ldh_ack_cycle: got %0d expected 3", ack_cyc); end
        tests++; if (bus.d_rdata !== 32'h0000BEEF) begin fails++; $display("FAIL ldh_rdata: got %h expected 0000beef", bus.d_rdata); end
        @(negedge clock);
    endtask

    task automatic test_simultaneous();
        int dcyc;
        int icyc;
        int exp_d;
        int exp_i;
`ifdef MEM_ARB_RR_EN
        exp_i = 5; exp_d = 8;
`else
        exp_d = 2; exp_i = 8;
`endif
        for (int p = 0; p < 2; p++) begin
            dcyc = 0; icyc = 0;
            bus.if_req = 1'b1; bus.if_addr = 32'd0;
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_addr = 32'd9;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clock);
                if (bus.d_ack) begin dcyc = k; bus.d_req = 1'b0; end
                if (bus.if_ack) begin icyc = k; bus.if_req = 1'b0; end
                if (dcyc != 0 && icyc != 0) break;
            end
            bus.d_req = 1'b0; bus.if_req = 1'b0;
            tests++; if (dcyc !== exp_d) begin fails++; $display("FAIL sim%0d_d_ack_cycle: got %0d expected %0d", p, dcyc, exp_d); end
            tests++; if (icyc !== exp_i) begin fails++; $display("FAIL sim%0d_if_ack_cycle: got %0d expected %0d", p, icyc, exp_i); end
            @(negedge clock);
        end
        tests++; if (bus.d_rdata !== 32'h000000BE) begin fails++; $display("FAIL sim_d_rdata: got %h expected 000000be", bus.d_rdata); end
        tests++; if (bus.if_rdata !== 32'h0020A223) begin fails++; $display("FAIL sim_if_rdata: got %h expected 0020a223", bus.if_rdata); end
    endtask

    task automatic test_wrap();
        int          ack_cyc;
        logic [31:0] seq;
        poke(6'd62, 8'h11);
        poke(6'd63, 8'h22);
        poke(6'd0,  8'h33);
        poke(6'd1,  8'h44);
        ack_cyc = 0; seq = 32'd0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h0000103E;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k <= 4) seq = {seq[23:0], 2'b00, bus.mem_addr};
            if (bus.d_ack) begin ack_cyc = k; break; end
        end
        bus.d_req = 1'b0;
        tests++; if (seq !== 32'h3E3F0001) begin fails++; $display("FAIL wrap_addr_seq: got %h expected 3e3f0001", seq); end
        tests++; if (ack_cyc !== 5) begin fails++; $display("FAIL wrap_ack_cycle: got %0d expected 5", ack_cyc); end
        tests++; if (bus.d_rdata !== 32'h44332211) begin fails++; $display("FAIL wrap_rdata: got %h expected 44332211", bus.d_rdata); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_store();
        logic saw_ack;
        poke(6'd4, 8'h11);
        poke(6'd5, 8'h22);
        poke(6'd6, 8'h33);
        poke(6'd7, 8'h44);
        saw_ack = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'd2;
        bus.d_addr = 32'd4; bus.d_wdata = 32'hA1B2C3D4;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            if (bus.d_ack) saw_ack = 1'b1;
        end
        reset_n = 1'b0;
        bus.d_req = 1'b0;
        #1;
        tests++; if (bus.d_ack !== 1'b0) begin fails++; $display("FAIL mrst_d_ack: got %b expected 0", bus.d_ack); end
        tests++; if (bus.if_ack !== 1'b0) begin fails++; $display("FAIL mrst_if_ack: got %b expected 0", bus.if_ack); end
        tests++; if (bus.d_rdata !== 32'd0) begin fails++; $display("FAIL mrst_d_rdata: got %h expected 0", bus.d_rdata); end
        tests++; if (bus.if_rdata !== 32'd0) begin fails++; $display("FAIL mrst_if_rdata: got %h expected 0", bus.if_rdata); end
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL mrst_mem_we: got %b expected 0", bus.mem_we); end
        tests++; if (bus.mem_addr !== 6'd0) begin fails++; $display("FAIL mrst_mem_addr: got %0d expected 0", bus.mem_addr); end
        tests++; if (bus.mem_wdata !== 8'd0) begin fails++; $display("FAIL mrst_mem_wdata: got %h expected 0", bus.mem_wdata); end
        @(negedge clock);
        @(negedge clock);
        tests++; if ({mem[7], mem[6], mem[5], mem[4]} !== 32'h4433C3D4) begin
            fails++; $display("FAIL mrst_partial_store: got %h expected 4433c3d4", {mem[7], mem[6], mem[5], mem[4]}); end
        tests++; if (saw_ack !== 1'b0) begin fails++; $display("FAIL mrst_no_ack: got %b expected 0", saw_ack); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int          first;
        int          second;
        logic [5:0]  addr4;
        logic [31:0] r1;
        logic [31:0] r2;
        first = 0; second = 0; addr4 = 6'd0; r1 = 32'd0; r2 = 32'd0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_addr = 32'd8;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k == 4) addr4 = bus.mem_addr;
            if (bus.d_ack) begin
                if (first == 0) begin
                    first = k; r1 = bus.d_rdata; bus.d_addr = 32'd11;
                end else begin
                    second = k; r2 = bus.d_rdata; bus.d_req = 1'b0;
                    break;
                end
            end
        end
        bus.d_req = 1'b0;
        tests++; if (first !== 2) begin fails++; $display("FAIL b2b_first_ack: got %0d expected 2", first); end
        tests++; if (r1 !== 32'h000000EF) begin fails++; $display("FAIL b2b_first_rdata: got %h expected 000000ef", r1); end
        tests++; if (addr4 !== 6'd11) begin fails++; $display("FAIL b2b_second_addr: got %0d expected 11", addr4); end
        tests++; if (second !== 5) begin fails++; $display("FAIL b2b_second_ack: got %0d expected 5", second); end
        tests++; if (r2 !== 32'h000000DE) begin fails++; $display("FAIL b2b_second_rdata: got %h expected 000000de", r2); end
        @(negedge clock);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n     = 1'b0;
        poke_en     = 1'b0;
        poke_addr   = 6'd0;
        poke_data   = 8'd0;
        bus.if_req  = 1'b0;
        bus.if_addr = 32'd0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_size  = 2'd0;
        bus.d_addr  = 32'd0;
        bus.d_wdata = 32'd0;
        @(negedge clock);
        for (int i = 0; i < 64; i++) begin
            poke(i[5:0], 8'd0);
        end
        test_reset();
        reset_n = 1'b1;
        @(negedge clock);
        test_fetch_word();
        test_store_load();
        test_simultaneous();
        test_wrap();
        test_reset_mid_store();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
